// File: rtl/decrypt_sequencer.sv
// LFSR stream decryptor: learns the tap pattern from a run of known spaces, then decodes a block in data memory.
// Optional PARITY_CHECK_EN counts bytes whose bit 7 disagrees with the parity of bits [6:0].
module decrypt_sequencer #(
  parameter int SRC_BASE  = 64,
  parameter int DST_BASE  = 0,
  parameter int MSG_LEN   = 64,
  parameter int TRAIN_LEN = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic [3:0] pattern_idx,
  output logic       pattern_found,
  output logic [5:0] parity_err_cnt,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    TRAIN     = 3'd2,
    DECODE_RD = 3'd3,
    DECODE_WR = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [7:0] SRC8 = 8'(SRC_BASE);
  localparam logic [7:0] DST8 = 8'(DST_BASE);
  localparam logic [8:0] TL   = 9'(TRAIN_LEN);
  localparam logic [8:0] ML1  = 9'(MSG_LEN - 1);

  function automatic logic [6:0] tap_of(input logic [3:0] p);
    case (p)
      4'd0:    return 7'h60;
      4'd1:    return 7'h48;
      4'd2:    return 7'h78;
      4'd3:    return 7'h72;
      4'd4:    return 7'h6A;
      4'd5:    return 7'h69;
      4'd6:    return 7'h5C;
      4'd7:    return 7'h7E;
      4'd8:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  state_t     state, state_nxt;
  logic       start_q;
  logic [8:0] cnt;
  logic [3:0] pat;
  logic [6:0] lfsr;
  logic [6:0] tap;
  logic [6:0] train_buf [TRAIN_LEN];
  logic [6:0] seed;
  logic [6:0] cur_tap;
  logic [6:0] probe;
  logic       match;
  logic       launch;

  assign launch    = start_q & ~Start;
  assign seed      = train_buf[0] ^ 7'h20;
  assign fsm_state = state;

  // Replays the candidate LFSR from the seed and compares it against every buffered training byte.
  always_comb begin
    cur_tap = tap_of(pat);
    probe   = seed;
    match   = 1'b1;
    for (int k = 1; k < TRAIN_LEN; k++) begin
      probe = lfsr_step(probe, cur_tap);
      if ((train_buf[k] ^ 7'h20) != probe) match = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (launch) state_nxt = LOAD;
      LOAD:      if (cnt == TL) state_nxt = TRAIN;
      TRAIN: begin
        if (match)           state_nxt = DECODE_RD;
        else if (pat == 4'd8) state_nxt = DONE;
      end
      DECODE_RD: state_nxt = DECODE_WR;
      DECODE_WR: state_nxt = (cnt == ML1) ? DONE : DECODE_RD;
      DONE:      if (Start) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      start_q       <= 1'b0;
      cnt           <= 9'd0;
      pat           <= 4'd0;
      lfsr          <= 7'd0;
      tap           <= 7'd0;
      pattern_idx   <= 4'd15;
      pattern_found <= 1'b0;
    end else begin
      start_q <= Start;
      case (state)
        IDLE: begin
          cnt <= 9'd0;
          pat <= 4'd0;
          if (launch) begin
            pattern_idx   <= 4'd15;
            pattern_found <= 1'b0;
          end
        end
        LOAD: begin
          // Read data lands one cycle after its address, so byte k is captured when cnt is k+1.
          for (int k = 0; k < TRAIN_LEN; k++)
            if (cnt == 9'(k + 1)) train_buf[k] <= mem_rdata[6:0];
          cnt <= (cnt == TL) ? 9'd0 : cnt + 9'd1;
        end
        TRAIN: begin
          pat <= pat + 4'd1;
          if (match) begin
            pattern_idx   <= pat;
            pattern_found <= 1'b1;
            lfsr          <= seed;
            tap           <= cur_tap;
          end else if (pat == 4'd8) begin
            pattern_idx   <= 4'd15;
            pattern_found <= 1'b0;
          end
        end
        DECODE_WR: begin
          lfsr <= lfsr_step(lfsr, tap);
          cnt  <= cnt + 9'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory port: mem_rd_en at an address returns mem_rdata on the next cycle; the two strobes are never high together.
  always_comb begin
    Ack       = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    case (state)
      LOAD: if (cnt < TL) begin
        mem_rd_en = 1'b1;
        mem_addr  = SRC8 + cnt[7:0];
      end
      DECODE_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = SRC8 + cnt[7:0];
      end
      DECODE_WR: begin
        mem_wr_en = 1'b1;
        mem_addr  = DST8 + cnt[7:0];
        mem_wdata = {1'b0, mem_rdata[6:0] ^ lfsr};
      end
      DONE:    Ack = 1'b1;
      default: ;
    endcase
  end

`ifdef PARITY_CHECK_EN
  logic [5:0] perr;
  always_ff @(posedge Clk) begin
    if (Reset)
      perr <= 6'd0;
    else if (state == IDLE && launch)
      perr <= 6'd0;
    else if (state == DECODE_WR && (mem_rdata[7] != ^mem_rdata[6:0]) && perr != 6'd63)
      perr <= perr + 6'd1;
  end
  assign parity_err_cnt = perr;
`else
  logic unused_parity_bit;
  assign unused_parity_bit = mem_rdata[7];
  assign parity_err_cnt    = 6'd0;
`endif

endmodule

// File: tb/tb_decrypt_sequencer.sv
// Bench for decrypt_sequencer: behavioural data memory, expected-write queue checked by a monitor, directed runs.
module tb_decrypt_sequencer;

  logic       Clk = 1'b0;
  logic       Reset, Start, Ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_rd_en, mem_wr_en;
  logic [3:0] pattern_idx;
  logic       pattern_found;
  logic [5:0] parity_err_cnt;
  logic [2:0] fsm_state;

  always #5 Clk = ~Clk;

  decrypt_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pattern_idx(pattern_idx), .pattern_found(pattern_found),
    .parity_err_cnt(parity_err_cnt), .fsm_state(fsm_state)
  );

  // Data memory with a backdoor write port for preloading
  logic [7:0] dm [256];
  logic       bd_we;
  logic [7:0] bd_addr, bd_data;
  always @(posedge Clk) begin
    if (mem_wr_en)  dm[mem_addr] <= mem_wdata;
    else if (bd_we) dm[bd_addr]  <= bd_data;
    mem_rdata <= dm[mem_addr];
  end

  logic [15:0] exp_q [$];
  logic [15:0] exp_word;
  int compared, mismatched;
  int strobes, wr_pulses, train_cycles;
  logic [7:0] plain [64];
  string msg;

  // Monitor: every write must match the head of the expected queue
  initial begin
    forever begin
      @(negedge Clk);
      if (fsm_state == 3'd2) train_cycles++;
      if (mem_rd_en || mem_wr_en) strobes++;
      if (mem_wr_en) begin
        wr_pulses++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr, mem_wdata);
        end else begin
          exp_word = exp_q.pop_front();
          if ({mem_rd_en, mem_addr, mem_wdata} !== {1'b0, exp_word}) begin
            mismatched++;
            $display("FAIL write: got rd %0b addr %0h data %0h, expected rd 0 addr %0h data %0h",
                     mem_rd_en, mem_addr, mem_wdata, exp_word[15:8], exp_word[7:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] nxt(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge Clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic clear_dst();
    for (int i = 0; i < 64; i++) poke(8'(i), 8'h00);
  endtask

  task automatic load_cipher(input logic [6:0] tap, input logic [6:0] seed);
    logic [6:0] s, c;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      c = plain[i][6:0] ^ s;
      poke(8'(64 + i), {^c, c});
      s = nxt(s, tap);
    end
  endtask

  task automatic push_expected(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({8'(i), plain[i]});
  endtask

  task automatic run(output int cyc);
    Start = 1'b0;
    cyc = 0;
    while (!Ack && cyc < 400) begin
      @(posedge Clk); #1;
      cyc++;
    end
  endtask

  task automatic check_dst(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (dm[i] !== plain[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic release_start();
    Start = 1'b1;
    @(posedge Clk); #1;
    check("ack_drop_on_start", Ack, 0);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  int lat;
  int waited;

  initial begin
    Reset = 1'b1; Start = 1'b1; bd_we = 1'b0; bd_addr = 8'd0; bd_data = 8'd0;
    compared = 0; mismatched = 0; strobes = 0; wr_pulses = 0; train_cycles = 0;
    msg = "A joke is a very serious thing.";
    for (int i = 0; i < 64; i++) begin
      if (i < 10)                plain[i] = 8'h20;
      else if (i - 10 < msg.len()) plain[i] = msg[i - 10];
      else                       plain[i] = 8'h5F;
    end

    // Reset values
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ack", Ack, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_pattern_idx", pattern_idx, 15);
    check("rst_pattern_found", pattern_found, 0);
    check("rst_parity_cnt", parity_err_cnt, 0);
    Reset = 1'b0;

    // Start held high keeps the block idle
    strobes = 0;
    repeat (200) @(posedge Clk);
    #1;
    check("idle_strobes", strobes, 0);
    check("idle_ack", Ack, 0);

    // Tap 0x60, seed 0x01
    clear_dst();
    load_cipher(7'h60, 7'h01);
    push_expected(64);
    run(lat);
    check("t0_ack_in_time", (lat <= 151) ? 1 : 0, 1);
    check("t0_pattern_idx", pattern_idx, 0);
    check("t0_pattern_found", pattern_found, 1);
    check("t0_queue_drained", exp_q.size(), 0);
    check("t0_parity_cnt", parity_err_cnt, 0);
    check_dst("t0_dst_contents");
    repeat (5) @(posedge Clk);
    #1;
    check("t0_ack_held", Ack, 1);
    check("t0_idx_held", pattern_idx, 0);
    release_start();

    // Tap 0x7B, seed 0x55: all nine patterns tried
    clear_dst();
    load_cipher(7'h7B, 7'h55);
    push_expected(64);
    train_cycles = 0;
    run(lat);
    check("t8_ack_in_time", (lat <= 151) ? 1 : 0, 1);
    check("t8_train_cycles", train_cycles, 9);
    check("t8_pattern_idx", pattern_idx, 8);
    check("t8_pattern_found", pattern_found, 1);
    check("t8_queue_drained", exp_q.size(), 0);
    check_dst("t8_dst_contents");
    release_start();

    // Non-LFSR source block: no pattern, no writes
    clear_dst();
    poke(8'd64, 8'h21);
    poke(8'd65, 8'h5F);
    for (int i = 66; i < 128; i++) poke(8'(i), 8'($urandom_range(0, 255)));
    wr_pulses = 0;
    run(lat);
    check("nomatch_ack", Ack, 1);
    check("nomatch_pattern_idx", pattern_idx, 15);
    check("nomatch_pattern_found", pattern_found, 0);
    check("nomatch_writes", wr_pulses, 0);
    release_start();

    // Reset during the write of byte 20
    clear_dst();
    load_cipher(7'h60, 7'h01);
    push_expected(21);
    Start = 1'b0;
    waited = 0;
    do begin
      @(negedge Clk);
      waited++;
    end while (!(mem_wr_en && mem_addr == 8'd20) && waited < 400);
    check("midrst_reached_byte20", (waited < 400) ? 1 : 0, 1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("midrst_ack", Ack, 0);
    check("midrst_wr_en", mem_wr_en, 0);
    check("midrst_state_idle", fsm_state, 0);
    Reset = 1'b0;
    strobes = 0;
    repeat (20) @(posedge Clk);
    #1;
    check("midrst_no_resume", strobes, 0);
    check("midrst_queue_drained", exp_q.size(), 0);
    check("midrst_byte20_kept", dm[20], plain[20]);
    check("midrst_byte21_untouched", dm[21], 0);
    Start = 1'b1;
    clear_dst();
    push_expected(64);
    run(lat);
    check("rerun_ack_in_time", (lat <= 151) ? 1 : 0, 1);
    check("rerun_pattern_idx", pattern_idx, 0);
    check("rerun_queue_drained", exp_q.size(), 0);
    check_dst("rerun_dst_contents");
    release_start();

    // Corrupted parity on source byte 6
    clear_dst();
    load_cipher(7'h60, 7'h01);
    poke(8'd70, dm[70] ^ 8'h80);
    push_expected(64);
    run(lat);
`ifdef PARITY_CHECK_EN
    check("parity_cnt", parity_err_cnt, 1);
`else
    check("parity_cnt", parity_err_cnt, 0);
`endif
    check("parity_byte6", dm[6], plain[6]);
    check("parity_queue_drained", exp_q.size(), 0);
    check_dst("parity_dst_contents");
    release_start();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decrypt_sequencer.md
DECRYPT_SEQUENCER -- requirements
Module: decrypt_sequencer

Interface
REQ-001 SHALL have parameter SRC_BASE, default 64, giving the first data-memory address of the encrypted block.
REQ-002 SHALL have parameter DST_BASE, default 0, giving the first data-memory address of the decoded block.
REQ-003 SHALL have parameter MSG_LEN, default 64, giving the number of bytes decoded.
REQ-004 SHALL have parameter TRAIN_LEN, default 10, giving the number of leading bytes known to be ASCII space (0x20).
REQ-005 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port Start, input, 1 bit: held high means hold idle; a 1-to-0 transition launches a run.
REQ-008 SHALL have port Ack, output, 1 bit: run complete.
REQ-009 SHALL have port mem_addr, output, 8 bits: data-memory address.
REQ-010 SHALL have ports mem_rd_en and mem_wr_en, output, 1 bit each: read and write strobes, never high together.
REQ-011 SHALL have port mem_wdata, output, 8 bits: write data.
REQ-012 SHALL have port mem_rdata, input, 8 bits: read data, valid one cycle after mem_rd_en.
REQ-013 SHALL have port pattern_idx, output, 4 bits: selected tap-table index 0-8, or 15 when none is found.
REQ-014 SHALL have port pattern_found, output, 1 bit: a tap pattern matched.
REQ-015 SHALL have port parity_err_cnt, output, 6 bits: count of parity errors.

Function
REQ-016 SHALL hold a constant tap table: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B (indices 0-8).
REQ-017 SHALL step the LFSR as next = {s[5:0], ^(s & tap)} on a 7-bit state s.
REQ-018 SHALL use states IDLE, LOAD, TRAIN, DECODE_RD, DECODE_WR, DONE.
REQ-019 SHALL go IDLE->LOAD on the cycle after Start is sampled 1 then 0.
REQ-020 SHALL, in LOAD, read SRC_BASE..SRC_BASE+TRAIN_LEN-1 on consecutive cycles and store bits [6:0] of each byte in a TRAIN_LEN x 7 buffer.
REQ-021 SHALL, when LOAD completes, set seed = buf[0] ^ 0x20.
REQ-022 SHALL, in TRAIN, test one pattern per cycle in order p=0..8.
- p matches iff buf[i] ^ 0x20 == lfsr_i(seed,p) for all i in 1..TRAIN_LEN-1.
- The first match sets pattern_idx=p and pattern_found=1, then goes to DECODE_RD with LFSR = seed.
REQ-023 SHALL, if no pattern matches after p=8, set pattern_idx=15 and pattern_found=0, issue no writes, and go to DONE.
REQ-024 SHALL, in DECODE_RD, assert mem_rd_en at SRC_BASE+i.
REQ-025 SHALL, in DECODE_WR, write {1'b0, mem_rdata[6:0] ^ lfsr} to DST_BASE+i, step the LFSR, increment i, and return to DECODE_RD; after i=MSG_LEN-1 it SHALL go to DONE.
REQ-026 SHALL compute addresses modulo 256 (8-bit wrap).
REQ-027 SHALL, in DONE, hold Ack=1 and keep pattern_idx and pattern_found until Start is high, then return to IDLE with Ack=0.
REQ-028 SHALL ignore a Start 1-to-0 transition outside IDLE.
REQ-029 SHALL raise Ack no more than TRAIN_LEN + 9 + 2*MSG_LEN + 4 cycles after Start falls (151 with defaults).
REQ-030 SHALL drive mem_rd_en, mem_wr_en, and mem_wdata to 0 in every state except LOAD and DECODE.

Reset
REQ-031 SHALL, when Reset=1 at a rising edge, go to IDLE and zero Ack, mem strobes, mem_addr, mem_wdata, pattern_found, and parity_err_cnt, and set pattern_idx=15.
REQ-032 SHALL, on reset mid-run, deassert mem_wr_en in the same edge and not resume; prior writes remain in memory.
REQ-033 SHALL take Reset over Start when both are asserted.

Configuration
REQ-034 SHALL use macro PARITY_CHECK_EN to control parity checking.
- Defined: in DECODE_WR, if mem_rdata[7] != ^mem_rdata[6:0], increment parity_err_cnt (saturating at 63); the written byte is unchanged. The counter clears when leaving IDLE for LOAD.
- Not defined: parity_err_cnt SHALL be constant 0 and no checking logic exists.

Verification
REQ-035 Tap 0x60, seed 0x01, preamble 10, message "A joke is a very serious thing." -> DM[0..63] equals the padded plaintext, pattern_idx=0, Ack within 151 cycles.
REQ-036 Tap 0x7B, seed 0x55 -> TRAIN takes 9 cycles, pattern_idx=8, decode correct.
REQ-037 DM[64..127] random non-LFSR bytes -> pattern_found=0, pattern_idx=15, no mem_wr_en pulse, Ack=1.
REQ-038 Reset asserted during the decode write of byte 20 -> next edge Ack=0, mem_wr_en=0; a rerun decodes fully.
REQ-039 With PARITY_CHECK_EN, flip bit 7 of DM[70] -> parity_err_cnt=1, DM[6] still correct; without the macro -> parity_err_cnt=0.
REQ-040 Start held high for 200 cycles -> no memory strobes, Ack=0.
